datapath_ctrl: RTL
==================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 s  in  1  start; sampled only in WAIT.
REQ-004 opcode  in  3  instruction class: 110 move, 101 ALU, 111 halt (halt only with macro).
REQ-005 op  in  2  sub-op: move 10 = immediate, 00 = register; ALU 00 ADD, 01 CMP, 10 AND, 11 MVN.
REQ-006 w  out  1  idle/ready, high only in WAIT.
REQ-007 nsel  out  3  one-hot register-field select: 100 Rn, 010 Rd, 001 Rm, 000 none.
REQ-008 vsel  out  2  writeback source: 01 sximm8, 11 datapath_out, 00 otherwise.
REQ-009 loada, loadb, loadc, loads, asel, bsel, write  out  1 each  datapath strobes.

Function
REQ-010 Moore FSM; all outputs SHALL be decoded from state and registered decode class only.
REQ-011 States: WAIT, DECODE, MOVIMM, GET_A, GET_B, EXEC, WRITE, plus HALT when configured.
REQ-012 WAIT: w=1, all strobes 0, nsel=000; s=1 at an edge -> DECODE, else stay.
REQ-013 DECODE SHALL latch opcode/op into an internal class register; later input changes SHALL be ignored until the next WAIT.
REQ-014 DECODE transitions: move/10 -> MOVIMM; move/00 -> GET_B; ALU 00/01/10 -> GET_A; ALU 11 -> GET_B; any other encoding -> WAIT with no strobe asserted.
REQ-015 MOVIMM: nsel=100, vsel=01, write=1; -> WAIT.
REQ-016 GET_A: nsel=100, loada=1; -> GET_B.
REQ-017 GET_B: nsel=001, loadb=1; -> EXEC.
REQ-018 EXEC: bsel=0; asel=1 for move/00 and MVN, else 0.
REQ-019 EXEC for CMP: loads=1, loadc=0; -> WAIT.
REQ-020 EXEC for all other classes: loadc=1, loads=0; -> WRITE.
REQ-021 WRITE: nsel=010, vsel=11, write=1; -> WAIT.
REQ-022 Latency from the s edge to w=1: MOV imm 3 cycles, CMP 5 cycles, ADD/AND 6 cycles, MVN/MOV reg 5 cycles.
REQ-023 write SHALL be high for exactly one cycle per writing instruction; CMP and illegal encodings SHALL never assert write or loadc.
REQ-024 s held high continuously SHALL start a new instruction on every entry to WAIT, with one WAIT cycle between instructions.
REQ-025 At most one of loada, loadb, loadc, write SHALL be high in any cycle.

Reset
REQ-026 reset_n=0 SHALL force WAIT immediately and asynchronously, from any state including mid-instruction.
REQ-027 While in reset: w=1, all strobes 0, nsel=000, vsel=00, class register cleared.
REQ-028 After reset_n rises, the first edge SHALL sample s normally.

Configuration
REQ-029 Macro DATAPATH_CTRL_HALT_EN, when defined: opcode 111 at DECODE -> HALT.
REQ-030 HALT: w=0, all strobes 0, s ignored; exit only via reset_n.
REQ-031 Without DATAPATH_CTRL_HALT_EN: no HALT state exists, and opcode 111 is illegal per REQ-014.

Verification
REQ-032 Reset mid-GET_B: assert reset_n=0 -> w=1 and loadb=0 within the same cycle, no clock needed; after release, s=1 starts a new instruction normally.
REQ-033 opcode=110, op=10, s pulse -> cycle 2 shows nsel=100, vsel=01, write=1; w=1 at cycle 3.
REQ-034 opcode=101, op=00, s pulse -> loada, loadb, loadc, write on consecutive cycles 2-5 with nsel 100/001/-/010; w=1 at cycle 6.
REQ-035 opcode=101, op=01 -> loads=1 in EXEC; loadc and write stay 0 throughout; w=1 at cycle 5.
REQ-036 opcode=101, op=11 and opcode=110, op=00 -> GET_A skipped; asel=1 in EXEC; write in WRITE with vsel=11.
REQ-037 opcode=111: with the macro, w stays 0 and s pulses are ignored until reset; without it, return to WAIT after DECODE with no strobe asserted.

Source files
------------

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
//   Moore sequencer for a small register-file/ALU datapath. An instruction is
//   started by s while idle in WAIT. The opcode and sub-op are captured in
//   DECODE. The FSM then steps through the register reads, the ALU execute
//   and the writeback strobes. Every output is a pure decode of the current
//   state and the captured instruction class.
//
// Optional feature: define DATAPATH_CTRL_HALT_EN to add a HALT state.
//   With the macro, opcode 111 parks the FSM in HALT until reset_n.
//   Without the macro, opcode 111 is treated as an illegal encoding.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   s        in   start; sampled only in WAIT
//   opcode   in   [2:0] 110 move, 101 ALU, 111 halt
//   op       in   [1:0] move: 10 imm, 00 reg; ALU: 00 ADD, 01 CMP, 10 AND, 11 MVN
//   w        out  high only in WAIT
//   nsel     out  [2:0] one-hot register field select: 100 Rn, 010 Rd, 001 Rm
//   vsel     out  [1:0] writeback source: 01 sximm8, 11 datapath_out
//   loada, loadb, loadc, loads, asel, bsel, write   out   datapath strobes
// -----------------------------------------------------------------------------
module datapath_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_MOVIMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_EXEC   = 3'd5,
`ifdef DATAPATH_CTRL_HALT_EN
    S_WRITE  = 3'd6,
    S_HALT   = 3'd7
`else
    S_WRITE  = 3'd6
`endif
  } state_t;

  // Instruction class encodings, stored as {opcode, op}.
  localparam logic [4:0] CLS_MOV_IMM = 5'b110_10;
  localparam logic [4:0] CLS_MOV_REG = 5'b110_00;
  localparam logic [4:0] CLS_ADD     = 5'b101_00;
  localparam logic [4:0] CLS_CMP     = 5'b101_01;
  localparam logic [4:0] CLS_AND     = 5'b101_10;
  localparam logic [4:0] CLS_MVN     = 5'b101_11;

  state_t     state_q, state_d;
  logic [4:0] cls_q, cls_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      cls_q   <= 5'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next state. The class is captured on the edge that leaves DECODE. After
  // that edge, opcode/op are not looked at again until the next instruction.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        cls_d = {opcode, op};
        casez ({opcode, op})
          CLS_MOV_IMM:                state_d = S_MOVIMM;
          CLS_MOV_REG, CLS_MVN:       state_d = S_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:  state_d = S_GET_A;
`ifdef DATAPATH_CTRL_HALT_EN
          5'b111_??:                  state_d = S_HALT;
`endif
          default:                    state_d = S_WAIT;
        endcase
      end
      S_MOVIMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = (cls_q == CLS_CMP) ? S_WAIT : S_WRITE;
      S_WRITE:  state_d = S_WAIT;
`ifdef DATAPATH_CTRL_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore output decode
  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    vsel  = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    write = 1'b0;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_MOVIMM: begin
        nsel  = 3'b100;
        vsel  = 2'b01;
        write = 1'b1;
      end
      S_GET_A:  begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GET_B:  begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_EXEC:   begin
        // Move-register and MVN pass only the B operand, so A is zeroed.
        asel = (cls_q == CLS_MOV_REG) || (cls_q == CLS_MVN);
        if (cls_q == CLS_CMP) loads = 1'b1;
        else                  loadc = 1'b1;
      end
      S_WRITE:  begin
        nsel  = 3'b010;
        vsel  = 2'b11;
        write = 1'b1;
      end
      default:  ;
    endcase
  end

endmodule
